// File: rtl/id_ex_operand_if.sv
// Decode-to-EX operand bundle: decode inputs, forwarding sources
// and the registered EX operands, stall and stall counter.
interface id_ex_operand_if #(
    parameter int WIDTH   = 64,
    parameter int REGBITS = 5,
    parameter int CNTW    = 32
);
    logic [WIDTH-1:0]   ReadData1;
    logic [WIDTH-1:0]   ReadData2;
    logic [REGBITS-1:0] ReadRegister1;
    logic [REGBITS-1:0] ReadRegister2;
    logic [REGBITS-1:0] id_Rd;
    logic               id_RegWrite;
    logic               id_MemRead;
    logic               id_valid;
    logic               flush;
    logic [REGBITS-1:0] exmem_Rd;
    logic               exmem_RegWrite;
    logic [WIDTH-1:0]   exmem_result;
    logic [REGBITS-1:0] memwb_Rd;
    logic               memwb_RegWrite;
    logic [WIDTH-1:0]   memwb_result;
    logic [WIDTH-1:0]   ex_A;
    logic [WIDTH-1:0]   ex_B;
    logic [REGBITS-1:0] ex_Rd;
    logic               ex_RegWrite;
    logic               ex_MemRead;
    logic               ex_valid;
    logic               stall;
    logic [CNTW-1:0]    stall_count;

    modport master (
        output ReadData1, ReadData2,
        output ReadRegister1, ReadRegister2,
        output id_Rd, id_RegWrite, id_MemRead,
        output id_valid, flush,
        output exmem_Rd, exmem_RegWrite, exmem_result,
        output memwb_Rd, memwb_RegWrite, memwb_result,
        input  ex_A, ex_B, ex_Rd,
        input  ex_RegWrite, ex_MemRead, ex_valid,
        input  stall, stall_count
    );

    modport slave (
        input  ReadData1, ReadData2,
        input  ReadRegister1, ReadRegister2,
        input  id_Rd, id_RegWrite, id_MemRead,
        input  id_valid, flush,
        input  exmem_Rd, exmem_RegWrite, exmem_result,
        input  memwb_Rd, memwb_RegWrite, memwb_result,
        output ex_A, ex_B, ex_Rd,
        output ex_RegWrite, ex_MemRead, ex_valid,
        output stall, stall_count
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX boundary: WB bypass at capture, EX/MEM and MEM/WB
// forwarding at output, load-use stall and stall counter.
module id_ex_operand_stage #(
    parameter int WIDTH   = 64,
    parameter int REGBITS = 5,
    parameter int ZREG    = 31,
    parameter int CNTW    = 32
) (
    input logic             clk,
    input logic             reset,
    id_ex_operand_if.slave  bus
);
    localparam logic [REGBITS-1:0] XZR = REGBITS'(ZREG);
    localparam logic [CNTW-1:0] ONE = CNTW'(1);

    typedef struct packed {
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [REGBITS-1:0] r1;
        logic [REGBITS-1:0] r2;
        logic [REGBITS-1:0] rd;
        logic               rw;
        logic               mr;
        logic               v;
    } id_ex_t;

    id_ex_t          q;
    id_ex_t          nxt;
    logic [CNTW-1:0] cnt;
    logic            stall;

    function automatic logic [WIDTH-1:0] capt(
        input logic [REGBITS-1:0] r,
        input logic [WIDTH-1:0]   rf
    );
        if (r == XZR)
            return '0;
        else if (bus.memwb_RegWrite && bus.memwb_Rd == r)
            return bus.memwb_result;
        else
            return rf;
    endfunction

    // EX/MEM is younger than MEM/WB, so it is checked first
    function automatic logic [WIDTH-1:0] fwd(
        input logic [REGBITS-1:0] r,
        input logic [WIDTH-1:0]   op
    );
        if (r == XZR)
            return '0;
        else if (bus.exmem_RegWrite && bus.exmem_Rd == r)
            return bus.exmem_result;
        else if (bus.memwb_RegWrite && bus.memwb_Rd == r)
            return bus.memwb_result;
        else
            return op;
    endfunction

    always_comb begin
        stall = bus.id_valid && q.v && q.mr
             && (q.rd != XZR)
             && (q.rd == bus.ReadRegister1
              || q.rd == bus.ReadRegister2);
    end

    always_comb begin
        nxt    = '0;
        nxt.a  = capt(bus.ReadRegister1, bus.ReadData1);
        nxt.b  = capt(bus.ReadRegister2, bus.ReadData2);
        nxt.r1 = bus.ReadRegister1;
        nxt.r2 = bus.ReadRegister2;
        nxt.rd = bus.id_Rd;
        if (!(bus.flush || stall)) begin
            nxt.rw = bus.id_RegWrite;
            nxt.mr = bus.id_MemRead;
            nxt.v  = bus.id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q   <= '0;
            cnt <= '0;
        end else begin
            q <= nxt;
            if (stall && cnt != '1)
                cnt <= cnt + ONE;
        end
    end

    assign bus.ex_A        = fwd(q.r1, q.a);
    assign bus.ex_B        = fwd(q.r2, q.b);
    assign bus.ex_Rd       = q.rd;
    assign bus.ex_RegWrite = q.rw;
    assign bus.ex_MemRead  = q.mr;
    assign bus.ex_valid    = q.v;
    assign bus.stall       = stall;
    assign bus.stall_count = cnt;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Randomised and directed bench for id_ex_operand_stage against
// a reference model of the pipeline-boundary rules.
module tb_id_ex_operand_stage;
    localparam int W    = 64;
    localparam int RB   = 5;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_ex_operand_if #(.WIDTH(W), .REGBITS(RB), .CNTW(CW)) bus ();

    id_ex_operand_stage #(
        .WIDTH(W), .REGBITS(RB), .ZREG(31), .CNTW(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // model of the instruction sitting in EX
    bit          m_valid, m_rw, m_mr;
    int          m_rd, m_r1, m_r2, m_cnt;
    logic [63:0] m_op1, m_op2;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic bit exp_stall();
        int a = int'(bus.ReadRegister1);
        int b = int'(bus.ReadRegister2);
        return bus.id_valid && m_valid && m_mr && m_rd != 31
            && (m_rd == a || m_rd == b);
    endfunction

    function automatic logic [63:0] capt(int r, logic [63:0] rf);
        if (r == 31) return 64'd0;
        if (bus.memwb_RegWrite && int'(bus.memwb_Rd) == r)
            return bus.memwb_result;
        return rf;
    endfunction

    function automatic logic [63:0] fwd(int r, logic [63:0] op);
        if (r == 31) return 64'd0;
        if (bus.exmem_RegWrite && int'(bus.exmem_Rd) == r)
            return bus.exmem_result;
        if (bus.memwb_RegWrite && int'(bus.memwb_Rd) == r)
            return bus.memwb_result;
        return op;
    endfunction

    task automatic idle();
        bus.ReadData1 = '0; bus.ReadData2 = '0;
        bus.ReadRegister1 = '0; bus.ReadRegister2 = '0;
        bus.id_Rd = '0; bus.id_RegWrite = 0;
        bus.id_MemRead = 0; bus.id_valid = 0; bus.flush = 0;
        bus.exmem_Rd = '0; bus.exmem_RegWrite = 0;
        bus.exmem_result = '0;
        bus.memwb_Rd = '0; bus.memwb_RegWrite = 0;
        bus.memwb_result = '0;
    endtask

    task automatic settle();
        #1;
        chk("stall", bus.stall, exp_stall());
        chk("ex_valid", bus.ex_valid, m_valid);
        chk("ex_RegWrite", bus.ex_RegWrite, m_rw);
        chk("ex_MemRead", bus.ex_MemRead, m_mr);
        chk("stall_count", bus.stall_count, m_cnt);
        if (m_valid) begin
            chk("ex_Rd", bus.ex_Rd, m_rd);
            chk("ex_A", bus.ex_A, fwd(m_r1, m_op1));
            chk("ex_B", bus.ex_B, fwd(m_r2, m_op2));
        end
    endtask

    task automatic clock();
        bit s, bub;
        s = exp_stall();
        @(posedge clk);
        if (reset) begin
            m_valid = 0; m_rw = 0; m_mr = 0;
            m_rd = 0; m_r1 = 0; m_r2 = 0; m_cnt = 0;
            m_op1 = 0; m_op2 = 0;
        end else begin
            if (s && m_cnt < MAXC) m_cnt++;
            m_op1 = capt(int'(bus.ReadRegister1), bus.ReadData1);
            m_op2 = capt(int'(bus.ReadRegister2), bus.ReadData2);
            m_r1 = int'(bus.ReadRegister1);
            m_r2 = int'(bus.ReadRegister2);
            m_rd = int'(bus.id_Rd);
            bub = bus.flush || s;
            m_valid = !bub && bus.id_valid;
            m_rw = !bub && bus.id_RegWrite;
            m_mr = !bub && bus.id_MemRead;
        end
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        clock();
    endtask

    task automatic load(int rd);
        idle();
        bus.id_valid = 1; bus.id_Rd = RB'(rd);
        bus.id_MemRead = 1; bus.id_RegWrite = 1;
        bus.ReadRegister1 = 5'd30; bus.ReadRegister2 = 5'd30;
        step();
    endtask

    function automatic logic [4:0] ridx();
        int r = $urandom_range(0, 6);
        return (r == 6) ? 5'd31 : 5'(r);
    endfunction

    initial begin
        int c0;
        idle();
        reset = 1;
        @(negedge clk);
        step();
        step();
        reset = 0;
        settle();
        chk("rst_A", bus.ex_A, 0);
        chk("rst_B", bus.ex_B, 0);
        chk("rst_Rd", bus.ex_Rd, 0);

        // EX/MEM outranks MEM/WB
        idle();
        bus.id_valid = 1; bus.id_Rd = 5'd2; bus.id_RegWrite = 1;
        bus.ReadRegister1 = 5'd1; bus.ReadRegister2 = 5'd3;
        step();
        idle();
        bus.exmem_Rd = 5'd1; bus.exmem_RegWrite = 1;
        bus.exmem_result = 64'h0000_0000_DEAD_BEEF;
        bus.memwb_Rd = 5'd1; bus.memwb_RegWrite = 1;
        bus.memwb_result = 64'h5;
        settle();
        chk("fwd_exmem", bus.ex_A, 64'hDEAD_BEEF);
        clock();

        // WB-cycle capture bypass
        idle();
        bus.id_valid = 1; bus.ReadRegister2 = 5'd7;
        bus.ReadData2 = 64'h11;
        bus.memwb_Rd = 5'd7; bus.memwb_RegWrite = 1;
        bus.memwb_result = 64'h22;
        step();
        idle();
        settle();
        chk("wb_bypass", bus.ex_B, 64'h22);
        clock();

        // load-use: one stall, one bubble, then issue
        load(4);
        idle();
        bus.id_valid = 1; bus.ReadRegister1 = 5'd4;
        c0 = m_cnt;
        settle();
        chk("lu_stall", bus.stall, 1);
        clock();
        settle();
        chk("lu_bubble", bus.ex_valid, 0);
        chk("lu_nostall", bus.stall, 0);
        chk("lu_count", bus.stall_count, c0 + 1);
        clock();
        settle();
        chk("lu_issue", bus.ex_valid, 1);
        clock();

        // XZR reads zero, never forwarded, never a hazard
        idle();
        bus.id_valid = 1; bus.ReadRegister1 = 5'd31;
        bus.ReadData1 = 64'hFFFF;
        bus.exmem_Rd = 5'd31; bus.exmem_RegWrite = 1;
        bus.exmem_result = 64'h1234;
        step();
        settle();
        chk("xzr_A", bus.ex_A, 0);
        clock();
        load(31);
        idle();
        bus.id_valid = 1; bus.ReadRegister1 = 5'd31;
        settle();
        chk("xzr_nohaz", bus.stall, 0);
        clock();

        // flush with stall, then flush alone
        load(5);
        idle();
        bus.id_valid = 1; bus.ReadRegister2 = 5'd5; bus.flush = 1;
        settle();
        chk("fs_stall", bus.stall, 1);
        clock();
        settle();
        chk("fs_bubble", bus.ex_valid, 0);
        clock();
        idle();
        bus.id_valid = 1; bus.id_RegWrite = 1; bus.flush = 1;
        c0 = m_cnt;
        step();
        settle();
        chk("fl_bubble", bus.ex_valid, 0);
        chk("fl_count", bus.stall_count, c0);
        clock();

        // reset while a stall is pending
        load(6);
        idle();
        bus.id_valid = 1; bus.ReadRegister1 = 5'd6;
        settle();
        chk("mr_stall", bus.stall, 1);
        reset = 1;
        clock();
        reset = 0;
        settle();
        chk("mr_A", bus.ex_A, 0);
        chk("mr_cnt", bus.stall_count, 0);
        chk("mr_stall0", bus.stall, 0);
        chk("mr_valid", bus.ex_valid, 0);
        clock();

        // random traffic; saturates the narrow counter
        for (int i = 0; i < 2000; i++) begin
            bus.ReadRegister1 = ridx();
            bus.ReadRegister2 = ridx();
            bus.ReadData1 = {$urandom, $urandom};
            bus.ReadData2 = {$urandom, $urandom};
            bus.id_Rd = ridx();
            bus.id_RegWrite = 1'($urandom);
            bus.id_MemRead = ($urandom_range(0, 2) == 0);
            bus.id_valid = ($urandom_range(0, 4) != 0);
            bus.flush = ($urandom_range(0, 7) == 0);
            bus.exmem_Rd = ridx();
            bus.exmem_RegWrite = 1'($urandom);
            bus.exmem_result = {$urandom, $urandom};
            bus.memwb_Rd = ridx();
            bus.memwb_RegWrite = 1'($urandom);
            bus.memwb_result = {$urandom, $urandom};
            reset = (i > 1000) && ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 0;
        idle();
        settle();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
